// File: rtl/sync_fifo_wl_if.sv
// Handshake bundle for sync_fifo_wl: write side, read side, status and error flags.
interface sync_fifo_wl_if #(
  parameter int DATA_WIDTH  = 10,
  parameter int DEPTH_WIDTH = 10
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;
  logic                  almost_full;
  logic [DEPTH_WIDTH:0]  wr_water_level;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_empty;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_full, almost_full, wr_water_level, rd_data, rd_valid,
           rd_empty, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_full, almost_full, wr_water_level, rd_data, rd_valid,
           rd_empty, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with water level, almost flags and 1/2-cycle read latency.
// Define SYNC_FIFO_ERR_FLAG_EN to enable sticky overflow/underflow flags.
module sync_fifo_wl #(
  parameter int DATA_WIDTH       = 10,
  parameter int DEPTH_WIDTH      = 10,
  parameter int OUTPUT_REG       = 1,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_wl_if.slave  fifo
);
  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int STAGES = (OUTPUT_REG != 0) ? 2 : 1;
  localparam logic [DEPTH_WIDTH:0] FULL_CNT = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_CNT   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_CNT   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_WIDTH:0]   count;
  logic                   full, empty, wr_acc, rd_acc;
  logic [STAGES:1]        vld_pipe;
  logic [DATA_WIDTH-1:0]  dat_s1;

  // All status is decoded from the registered occupancy only.
  assign full                = (count == FULL_CNT);
  assign empty               = (count == '0);
  assign fifo.wr_full        = full;
  assign fifo.rd_empty       = empty;
  assign fifo.almost_full    = (count >= AF_CNT);
  assign fifo.almost_empty   = (count <= AE_CNT);
  assign fifo.wr_water_level = count;

  assign wr_acc = fifo.wr_en & ~full;
  assign rd_acc = fifo.rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (DEPTH_WIDTH+1)'(1);
        2'b01:   count <= count - (DEPTH_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= fifo.wr_data;
  end

  // Valid shift register; reset flushes any words still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= STAGES'({vld_pipe, rd_acc});
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      dat_s1 <= '0;
    else if (rd_acc) dat_s1 <= mem[rd_ptr];
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] dat_s2;
      always_ff @(posedge clk) begin
        if (!rst_n)           dat_s2 <= '0;
        else if (vld_pipe[1]) dat_s2 <= dat_s1;
      end
      assign fifo.rd_data = dat_s2;
    end else begin : g_noreg
      assign fifo.rd_data = dat_s1;
    end
  endgenerate

  assign fifo.rd_valid = vld_pipe[STAGES];

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic ovf_q, unf_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (fifo.wr_en & full)  ovf_q <= 1'b1;
      if (fifo.rd_en & empty) unf_q <= 1'b1;
    end
  end
  assign fifo.overflow  = ovf_q;
  assign fifo.underflow = unf_q;
`else
  assign fifo.overflow  = 1'b0;
  assign fifo.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_wl.sv
// Randomized scoreboard bench for sync_fifo_wl against a queue-based reference model.
module tb_sync_fifo_wl;
  localparam int DW = 10, AW = 10, DEPTH = 1024, OREG = 1, AFN = 1020, AEN = 4;
`ifdef SYNC_FIFO_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_wl_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bus ();

  sync_fifo_wl #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .OUTPUT_REG(OREG),
    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo(bus)
  );

  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  exp_t          expq[$];
  logic [DW-1:0] model[$];
  int            cyc = 0, checks = 0, errors = 0, popped = 0;
  bit            mon_en = 1'b0, m_ov = 1'b0, m_un = 1'b0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, then apply the FIFO rules to the model after the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    bit aw, ar, ow, ur;
    exp_t e;
    bus.wr_en = w; bus.wr_data = d; bus.rd_en = r;
    aw = w && model.size() < DEPTH;
    ar = r && model.size() > 0;
    ow = w && model.size() == DEPTH;
    ur = r && model.size() == 0;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model.delete(); expq.delete();
      m_ov = 1'b0; m_un = 1'b0; last_data = '0;
    end else begin
      if (ERR_EN && ow) m_ov = 1'b1;
      if (ERR_EN && ur) m_un = 1'b1;
      if (ar) begin
        e.d = model.pop_front();
        e.due = cyc + OREG;
        expq.push_back(e);
      end
      if (aw) model.push_back(d);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // Monitor: pops expected words when due, checks status against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      bit due_now;
      due_now = expq.size() > 0 && expq[0].due == cyc;
      chk("rd_valid", bus.rd_valid, due_now);
      if (due_now) begin
        if (bus.rd_valid) begin
          chk("rd_data", bus.rd_data, expq[0].d);
          popped++;
        end
        last_data = expq[0].d;
        void'(expq.pop_front());
      end else begin
        chk("rd_data_hold", bus.rd_data, last_data);
      end
      chk("water_level", bus.wr_water_level, model.size());
      chk("wr_full", bus.wr_full, model.size() == DEPTH);
      chk("rd_empty", bus.rd_empty, model.size() == 0);
      chk("almost_full", bus.almost_full, model.size() >= AFN);
      chk("almost_empty", bus.almost_empty, model.size() <= AEN);
      chk("overflow", bus.overflow, m_ov);
      chk("underflow", bus.underflow, m_un);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, bus.rd_empty, 1);
    chk({tag, "_aempty"}, bus.almost_empty, 1);
    chk({tag, "_full"}, bus.wr_full, 0);
    chk({tag, "_afull"}, bus.almost_full, 0);
    chk({tag, "_wl"}, bus.wr_water_level, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
    chk({tag, "_unf"}, bus.underflow, 0);
  endtask

  initial begin
    int wrote, p0;
    bit w, r;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk_reset_vals("reset");

    // Three words in, three out.
    step(1'b1, 10'h001, 1'b0);
    step(1'b1, 10'h002, 1'b0);
    step(1'b1, 10'h003, 1'b0);
    chk("wl_three", bus.wr_water_level, 3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("wl_zero", bus.wr_water_level, 0);
    idle(3);

    // Fill to full, then one dropped write.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'($urandom), 1'b0);
      if (i == AFN - 2) chk("afull_before", bus.almost_full, 0);
      if (i == AFN - 1) chk("afull_at", bus.almost_full, 1);
      if (i == DEPTH - 2) chk("full_before", bus.wr_full, 0);
    end
    chk("full_at", bus.wr_full, 1);
    step(1'b1, DW'($urandom), 1'b0);
    chk("wl_after_drop", bus.wr_water_level, DEPTH);
    chk("ovf_after_drop", bus.overflow, ERR_EN);

    // Full with both requests: read wins.
    step(1'b1, DW'($urandom), 1'b1);
    chk("wl_full_both", bus.wr_water_level, DEPTH - 1);
    chk("full_both_flag", bus.wr_full, 0);
    for (int i = 0; i < DEPTH + 4 && model.size() > 0; i++) step(1'b0, '0, 1'b1);
    idle(3);

    // Read on empty, then both on empty.
    step(1'b0, '0, 1'b1);
    chk("wl_rd_empty", bus.wr_water_level, 0);
    chk("unf_rd_empty", bus.underflow, ERR_EN);
    idle(2);
    step(1'b1, 10'h155, 1'b1);
    chk("wl_empty_both", bus.wr_water_level, 1);
    idle(3);
    step(1'b0, '0, 1'b1);
    idle(3);

    // Streamed traffic with occupancy capped at 8.
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    p0 = popped;
    wrote = 0;
    for (int it = 0; it < 20000 && wrote < 3000; it++) begin
      w = ($urandom_range(0, 1) == 1) && model.size() < 8;
      r = ($urandom_range(0, 1) == 1);
      if (w) wrote++;
      step(w, DW'($urandom), r);
    end
    for (int i = 0; i < 16 && model.size() > 0; i++) step(1'b0, '0, 1'b1);
    idle(4);
    chk("stream_written", wrote, 3000);
    chk("stream_read", popped - p0, 3000);

    // Reset with stored words and reads in flight.
    for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("pre_rst_wl", bus.wr_water_level, 5);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk_reset_vals("mid_reset");
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
